// File: rtl/cram_async_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cram_async_ctrl
// Description : Asynchronous-mode CellularRAM controller with one command in
//               flight, a four-state FSM and fully registered pin outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module cram_async_ctrl #(
  parameter int CHIPS = 2,
  parameter int T_ADV = 2,
  parameter int T_ACC = 6,
  parameter int T_REC = 2,
  localparam int AW = (CHIPS == 1) ? 22 : 23
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic          cmd_cre,
  input  logic [AW-1:0] cmd_addr,
  input  logic [15:0]   cmd_wdata,
  input  logic [1:0]    cmd_be,
  output logic          rsp_valid,
  output logic [15:0]   rsp_rdata,
  output logic [5:0]    cram_a,
  output logic [15:0]   cram_dq_out,
  output logic          cram_dq_oe,
  input  logic [15:0]   cram_dq_in,
  output logic          cram_clk,
  output logic          cram_adv_n,
  output logic          cram_cre,
  output logic          cram_ce0_n,
  output logic          cram_ce1_n,
  output logic          cram_oe_n,
  output logic          cram_we_n,
  output logic          cram_ub_n,
  output logic          cram_lb_n,
  input  logic          cram_wait
);

  localparam int T_MAX = (T_ADV > T_ACC) ? ((T_ADV > T_REC) ? T_ADV : T_REC)
                                         : ((T_ACC > T_REC) ? T_ACC : T_REC);
  localparam int CW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  generate
    if (CHIPS != 1 && CHIPS != 2) begin : g_bad_chips
      $error("cram_async_ctrl: CHIPS must be 1 or 2");
    end
    if (T_ADV < 1 || T_ACC < 1 || T_REC < 1) begin : g_bad_timing
      $error("cram_async_ctrl: T_ADV, T_ACC and T_REC must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADDR    = 2'd1,
    ACCESS  = 2'd2,
    RECOVER = 2'd3
  } state_t;

  state_t          r_state, w_state_d;
  logic [CW-1:0]   r_cnt, w_cnt_d;
  logic            r_write, r_cre;
  logic [AW-1:0]   r_addr;
  logic [15:0]     r_wdata;
  logic [1:0]      r_be;

  logic            w_accept, w_last;
  logic            w_write, w_cre, w_sel;
  logic [AW-1:0]   w_addr;
  logic [15:0]     w_wdata;
  logic [1:0]      w_be;

  logic [5:0]      w_a;
  logic [15:0]     w_dq_out;
  logic            w_dq_oe, w_adv_n, w_cre_pin, w_ce0_n, w_ce1_n;
  logic            w_oe_n, w_we_n, w_ub_n, w_lb_n;

  logic            w_unused;
  assign w_unused = cram_wait;

  assign cram_clk = 1'b0;
  assign w_accept = (r_state == IDLE) && cmd_valid && cmd_ready;
  assign w_last   = (r_cnt == '0);

  // Pins are registered from the next state, so the accepting edge must see
  // the incoming command rather than the not-yet-latched copy.
  assign w_write = w_accept ? cmd_write : r_write;
  assign w_cre   = w_accept ? cmd_cre   : r_cre;
  assign w_addr  = w_accept ? cmd_addr  : r_addr;
  assign w_wdata = w_accept ? cmd_wdata : r_wdata;
  assign w_be    = w_accept ? cmd_be    : r_be;

  generate
    if (CHIPS == 2) begin : g_two_chips
      assign w_sel = w_addr[AW-1];
    end else begin : g_one_chip
      assign w_sel = 1'b0;
    end
  endgenerate

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_d = ADDR;
          w_cnt_d   = CW'(T_ADV - 1);
        end
      end
      ADDR: begin
        if (w_last) begin
          w_state_d = ACCESS;
          w_cnt_d   = CW'(T_ACC - 1);
        end else begin
          w_cnt_d = r_cnt - 1'b1;
        end
      end
      ACCESS: begin
        if (w_last) begin
          w_state_d = RECOVER;
          w_cnt_d   = CW'(T_REC - 1);
        end else begin
          w_cnt_d = r_cnt - 1'b1;
        end
      end
      RECOVER: begin
        if (w_last) begin
          w_state_d = IDLE;
        end else begin
          w_cnt_d = r_cnt - 1'b1;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_comb begin
    w_a       = 6'd0;
    w_dq_out  = 16'd0;
    w_dq_oe   = 1'b0;
    w_adv_n   = 1'b1;
    w_cre_pin = 1'b0;
    w_ce0_n   = 1'b1;
    w_ce1_n   = 1'b1;
    w_oe_n    = 1'b1;
    w_we_n    = 1'b1;
    w_ub_n    = 1'b1;
    w_lb_n    = 1'b1;
    if (w_state_d == ADDR || w_state_d == ACCESS) begin
      w_a       = w_addr[21:16];
      w_cre_pin = w_cre;
      w_ce0_n   = w_sel;
      w_ce1_n   = ~w_sel;
    end
    if (w_state_d == ADDR) begin
      w_adv_n  = 1'b0;
      w_dq_oe  = 1'b1;
      w_dq_out = w_addr[15:0];
    end else if (w_state_d == ACCESS) begin
      if (w_write) begin
        w_we_n   = 1'b0;
        w_dq_oe  = 1'b1;
        w_dq_out = w_wdata;
        w_ub_n   = ~w_be[1];
        w_lb_n   = ~w_be[0];
      end else begin
        w_oe_n = 1'b0;
        w_ub_n = 1'b0;
        w_lb_n = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_write     <= 1'b0;
      r_cre       <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= 16'd0;
      r_be        <= 2'b00;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 16'd0;
      cram_a      <= 6'd0;
      cram_dq_out <= 16'd0;
      cram_dq_oe  <= 1'b0;
      cram_adv_n  <= 1'b1;
      cram_cre    <= 1'b0;
      cram_ce0_n  <= 1'b1;
      cram_ce1_n  <= 1'b1;
      cram_oe_n   <= 1'b1;
      cram_we_n   <= 1'b1;
      cram_ub_n   <= 1'b1;
      cram_lb_n   <= 1'b1;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      cmd_ready <= (w_state_d == IDLE);
      if (w_accept) begin
        r_write <= cmd_write;
        r_cre   <= cmd_cre;
        r_addr  <= cmd_addr;
        r_wdata <= cmd_wdata;
        r_be    <= cmd_be;
      end
      rsp_valid <= (r_state == ACCESS) && w_last;
      if ((r_state == ACCESS) && w_last && !r_write) begin
        rsp_rdata <= cram_dq_in;
      end
      cram_a      <= w_a;
      cram_dq_out <= w_dq_out;
      cram_dq_oe  <= w_dq_oe;
      cram_adv_n  <= w_adv_n;
      cram_cre    <= w_cre_pin;
      cram_ce0_n  <= w_ce0_n;
      cram_ce1_n  <= w_ce1_n;
      cram_oe_n   <= w_oe_n;
      cram_we_n   <= w_we_n;
      cram_ub_n   <= w_ub_n;
      cram_lb_n   <= w_lb_n;
    end
  end

endmodule
`default_nettype wire
